// File: rtl/pipeline_pkg.sv
// Shared constants and fetch FSM encoding for the 5-stage pipeline.
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} fetch_state_e;
endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter: reset value, +4 increment and redirect load.
module fetch_pc_gen
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] P_RESET_PC = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_advance,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_load_pc,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc4
);
  // Wraps modulo 2^32 without a carry out.
  assign o_pc4 = o_pc + 32'd4;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          o_pc <= P_RESET_PC;
    else if (i_load)    o_pc <= i_load_pc;
    else if (i_advance) o_pc <= o_pc4;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: drives the instruction memory address, captures the IF/ID register,
// handles stall, redirect and halt on EBREAK.
module instr_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] P_RESET_PC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] P_NOP        = NOP_INSTR,
  parameter logic [XLEN-1:0] P_HALT_INSTR = EBREAK_INSTR
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic [XLEN-1:0] o_adr,
  input  logic [XLEN-1:0] i_instr,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_ifid_instr,
  output logic [XLEN-1:0] o_ifid_pc,
  output logic [XLEN-1:0] o_ifid_pc4,
  output logic            o_ifid_valid,
  output logic            o_halted,
  output logic            o_misalign
);
  fetch_state_e    state, state_nxt;
  logic            pc_adv, pc_load, ifid_cap, ifid_flush, misalign_nxt;
  logic [XLEN-1:0] pc, pc4;

  fetch_pc_gen #(.P_RESET_PC(P_RESET_PC)) u_pc_gen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_advance (pc_adv),
    .i_load    (pc_load),
    .i_load_pc ({i_redirect_pc[XLEN-1:2], 2'b00}),
    .o_pc      (pc),
    .o_pc4     (pc4)
  );

  assign o_adr    = pc;
  assign o_halted = (state == ST_HALT);

  always_comb begin
    state_nxt    = state;
    pc_adv       = 1'b0;
    pc_load      = 1'b0;
    ifid_cap     = 1'b0;
    ifid_flush   = 1'b0;
    misalign_nxt = 1'b0;
    case (state)
      // Memory output settles during this cycle; nothing is captured.
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_redirect) begin
          pc_load      = 1'b1;
          ifid_flush   = 1'b1;
          misalign_nxt = |i_redirect_pc[1:0];
        end else if (!i_stall) begin
          pc_adv   = 1'b1;
          ifid_cap = 1'b1;
          if (i_instr == P_HALT_INSTR) state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        // PC stays frozen; stall only delays flushing the captured EBREAK.
        if (i_redirect) begin
          pc_load      = 1'b1;
          ifid_flush   = 1'b1;
          misalign_nxt = |i_redirect_pc[1:0];
          state_nxt    = ST_RUN;
        end else if (!i_stall) begin
          ifid_flush = 1'b1;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_BOOT;
      o_ifid_instr <= P_NOP;
      o_ifid_pc    <= '0;
      o_ifid_pc4   <= '0;
      o_ifid_valid <= 1'b0;
      o_misalign   <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_misalign <= misalign_nxt;
      if (ifid_cap) begin
        o_ifid_instr <= i_instr;
        o_ifid_pc    <= pc;
        o_ifid_pc4   <= pc4;
        o_ifid_valid <= 1'b1;
      end else if (ifid_flush) begin
        o_ifid_instr <= P_NOP;
        o_ifid_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a behavioural fetch model.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr, instr, redirect_pc;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
  logic        ifid_valid, halted, misalign;

  logic [31:0] mem [0:63];

  int checks = 0;
  int failures = 0;

  // Model state: 0 = waiting first edge, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4;
  logic        m_valid, m_mis;

  always #5 clk = ~clk;

  assign instr = mem[adr[7:2]];

  instr_fetch_unit dut (
    .i_clk(clk), .i_rst(rst), .o_adr(adr), .i_instr(instr),
    .i_stall(stall), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_ifid_instr(ifid_instr), .o_ifid_pc(ifid_pc), .o_ifid_pc4(ifid_pc4),
    .o_ifid_valid(ifid_valid), .o_halted(halted), .o_misalign(misalign)
  );

  function automatic logic [130:0] dut_vec();
    return {adr, ifid_instr, ifid_pc, ifid_pc4, ifid_valid, halted, misalign};
  endfunction

  function automatic logic [130:0] mdl_vec();
    return {m_pc, m_instr, m_ifpc, m_ifpc4, m_valid, (m_mode == 2), m_mis};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_instr = NOP; m_ifpc = 0; m_ifpc4 = 0;
    m_valid = 0; m_mis = 0;
  endtask

  // Advance the model by one edge using current inputs, then clock the DUT.
  task automatic cycle();
    logic [31:0] fetched;
    fetched = mem[m_pc[7:2]];
    m_mis = 1'b0;
    if (m_mode == 0) m_mode = 1;
    else if (redirect) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_instr = NOP; m_valid = 0;
      m_mis = (redirect_pc % 4) != 0;
      m_mode = 1;
    end else if (!stall) begin
      if (m_mode == 1) begin
        m_instr = fetched; m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_valid = 1;
        m_pc = m_pc + 4;
        if (fetched == EBK) m_mode = 2;
      end else begin
        m_instr = NOP; m_valid = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 0; redirect = 0; redirect_pc = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== {32'h0, NOP, 32'h0, 32'h0, 3'b000}) begin
      failures++; $display("FAIL reset_state: got %h expected %h", dut_vec(), {32'h0, NOP, 32'h0, 32'h0, 3'b000});
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_adr [0:3];
    exp_adr[0] = 32'h0; exp_adr[1] = 32'h4; exp_adr[2] = 32'h8; exp_adr[3] = 32'hC;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (adr !== exp_adr[i]) begin
        failures++; $display("FAIL seq_adr[%0d]: got %h expected %h", i, adr, exp_adr[i]);
      end
      if (i > 0) begin
        checks++;
        if ({ifid_pc, ifid_pc4, ifid_valid, ifid_instr} !== {exp_adr[i-1], exp_adr[i-1] + 32'd4, 1'b1, mem[i-1]}) begin
          failures++; $display("FAIL seq_ifid[%0d]: got pc=%h pc4=%h v=%b ins=%h expected pc=%h", i, ifid_pc, ifid_pc4, ifid_valid, ifid_instr, exp_adr[i-1]);
        end
      end
    end
    cycle();
    checks++;
    if (dut_vec() !== mdl_vec() || adr !== 32'h10) begin
      failures++; $display("FAIL seq_model: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (adr !== 32'h10 || ifid_pc !== 32'hC || ifid_valid !== 1'b1) begin
        failures++; $display("FAIL stall_hold[%0d]: got adr=%h pc=%h v=%b expected adr=10 pc=c v=1", i, adr, ifid_pc, ifid_valid);
      end
    end
    stall = 0;
    cycle();
    checks++;
    if (ifid_pc !== 32'h10 || adr !== 32'h14) begin
      failures++; $display("FAIL stall_release: got pc=%h adr=%h expected pc=10 adr=14", ifid_pc, adr);
    end
  endtask

  task automatic test_redirect();
    for (int k = 0; k < 2; k++) begin
      redirect = 1; redirect_pc = 32'h60; stall = (k == 1);
      cycle();
      redirect = 0; stall = 0;
      checks++;
      if (adr !== 32'h60 || ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
        failures++; $display("FAIL redirect_flush[%0d]: got adr=%h v=%b ins=%h expected adr=60 v=0", k, adr, ifid_valid, ifid_instr);
      end
      cycle();
      checks++;
      if (ifid_pc !== 32'h60 || ifid_valid !== 1'b1 || dut_vec() !== mdl_vec()) begin
        failures++; $display("FAIL redirect_capture[%0d]: got pc=%h v=%b expected pc=60 v=1", k, ifid_pc, ifid_valid);
      end
    end
  endtask

  task automatic test_misalign();
    redirect = 1; redirect_pc = 32'h62;
    cycle();
    redirect = 0;
    checks++;
    if (adr !== 32'h60 || misalign !== 1'b1) begin
      failures++; $display("FAIL misalign_pulse: got adr=%h mis=%b expected adr=60 mis=1", adr, misalign);
    end
    cycle();
    checks++;
    if (misalign !== 1'b0) begin
      failures++; $display("FAIL misalign_clear: got %b expected 0", misalign);
    end
  endtask

  task automatic test_halt();
    redirect = 1; redirect_pc = 32'h20;
    cycle();
    redirect = 0;
    for (int i = 0; i < 5; i++) cycle();
    checks++;
    if (ifid_instr !== EBK || halted !== 1'b1 || adr !== 32'h34 || ifid_pc !== 32'h30) begin
      failures++; $display("FAIL halt_enter: got ins=%h h=%b adr=%h pc=%h expected ebreak h=1 adr=34 pc=30", ifid_instr, halted, adr, ifid_pc);
    end
    stall = 1;
    cycle();
    checks++;
    if (ifid_instr !== EBK || ifid_valid !== 1'b1 || adr !== 32'h34) begin
      failures++; $display("FAIL halt_stall_hold: got ins=%h v=%b adr=%h expected ebreak v=1 adr=34", ifid_instr, ifid_valid, adr);
    end
    stall = 0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (ifid_valid !== 1'b0 || ifid_instr !== NOP || adr !== 32'h34 || halted !== 1'b1) begin
        failures++; $display("FAIL halt_flush[%0d]: got v=%b ins=%h adr=%h h=%b expected v=0 nop adr=34 h=1", i, ifid_valid, ifid_instr, adr, halted);
      end
    end
    redirect = 1; redirect_pc = 32'h0;
    cycle();
    redirect = 0;
    checks++;
    if (halted !== 1'b0 || adr !== 32'h0) begin
      failures++; $display("FAIL halt_exit: got h=%b adr=%h expected h=0 adr=0", halted, adr);
    end
    cycle();
    checks++;
    if (ifid_pc !== 32'h0 || ifid_valid !== 1'b1 || adr !== 32'h4) begin
      failures++; $display("FAIL halt_resume: got pc=%h v=%b adr=%h expected pc=0 v=1 adr=4", ifid_pc, ifid_valid, adr);
    end
    // Redirect while EBREAK is at the fetch address must not halt.
    redirect = 1; redirect_pc = 32'h30;
    cycle();
    redirect_pc = 32'h40;
    cycle();
    redirect = 0;
    checks++;
    if (halted !== 1'b0 || adr !== 32'h40) begin
      failures++; $display("FAIL redirect_over_ebreak: got h=%b adr=%h expected h=0 adr=40", halted, adr);
    end
  endtask

  task automatic test_wrap();
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 0;
    cycle();
    checks++;
    if (adr !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC || ifid_pc4 !== 32'h0) begin
      failures++; $display("FAIL pc_wrap: got adr=%h pc=%h pc4=%h expected adr=0 pc=fffffffc pc4=0", adr, ifid_pc, ifid_pc4);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      stall       = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom() : {24'h0, 8'($urandom())};
      cycle();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++; bad++;
        if (bad < 5) $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), mdl_vec());
      end
    end
    stall = 0; redirect = 0;
  endtask

  task automatic test_async_reset();
    redirect = 1; redirect_pc = 32'h80;
    cycle();
    redirect = 0;
    cycle(); cycle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== {32'h0, NOP, 32'h0, 32'h0, 3'b000}) begin
      failures++; $display("FAIL async_reset: got %h expected %h", dut_vec(), {32'h0, NOP, 32'h0, 32'h0, 3'b000});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(); cycle();
    checks++;
    if (dut_vec() !== mdl_vec() || adr !== 32'h4) begin
      failures++; $display("FAIL post_reset_fetch: got %h expected %h", dut_vec(), mdl_vec());
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | (i << 7) | 32'h13;
    mem[12] = EBK;
    redirect_pc = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misalign();
    test_halt();
    test_wrap();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
